alu_pipe: RTL and testbench



---
 rtl/alu_pipe_if.sv | 38 +++
 rtl/alu_pipe.sv | 149 ++++++++++++++
 tb/tb_alu_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// ============================================================================
// Module      : alu_pipe_if
// Description : Operand-issue and result handshake bundle for alu_pipe.
//               The master side issues operands and consumes results;
//               the slave side is the pipelined ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface alu_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       s;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] F;
    logic             flag_c;
    logic             flag_v;
    logic             flag_z;
    logic             flag_n;

    modport master (
        output in_valid, s, A, B, out_ready,
        input  in_ready, out_valid, F, flag_c, flag_v, flag_z, flag_n
    );

    modport slave (
        input  in_valid, s, A, B, out_ready,
        output in_ready, out_valid, F, flag_c, flag_v, flag_z, flag_n
    );
endinterface

`default_nettype wire

// File: rtl/alu_pipe.sv
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage pipelined 8-operation ALU with valid/ready
//               handshake, full backpressure and registered C/V/Z/N flags.
//               Optional macro ALU_SAT_EN: unsigned saturation of add/sub
//               results (flags still report the raw condition).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst,
    alu_pipe_if.slave  bus
);
    localparam int MSB = WIDTH - 1;

    // Stage 1: captured operands
    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;

    // Stage 2: result and flags
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_f_q;
    logic             s2_c_q, s2_v_q, s2_z_q, s2_n_q;

    // Handshake
    logic s2_load;
    logic in_ready;
    logic in_fire;

    // Stage-1 combinational result
    logic [WIDTH:0]   add_w, amb_w, bma_w;
    logic [WIDTH-1:0] f_d;
    logic             c_d, v_d, z_d, n_d;

    // S2 loads when empty or its result is being taken; S1 drains with it.
    assign s2_load  = !s2_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign in_fire  = bus.in_valid && in_ready;

    // S1 stays occupied only if it held data that could not advance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // ALU datapath: WIDTH+1-bit arithmetic so bit WIDTH gives carry/borrow.
    always_comb begin
        add_w = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        amb_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        bma_w = {1'b0, s1_b_q} - {1'b0, s1_a_q};
        f_d   = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        case (s1_op_q)
            3'd1: begin
                f_d = bma_w[MSB:0];
                c_d = bma_w[WIDTH];
                v_d = (s1_b_q[MSB] != s1_a_q[MSB]) && (f_d[MSB] != s1_b_q[MSB]);
`ifdef ALU_SAT_EN
                if (c_d) f_d = '0;
`endif
            end
            3'd2: begin
                f_d = amb_w[MSB:0];
                c_d = amb_w[WIDTH];
                v_d = (s1_a_q[MSB] != s1_b_q[MSB]) && (f_d[MSB] != s1_a_q[MSB]);
`ifdef ALU_SAT_EN
                if (c_d) f_d = '0;
`endif
            end
            3'd3: begin
                f_d = add_w[MSB:0];
                c_d = add_w[WIDTH];
                v_d = (s1_a_q[MSB] == s1_b_q[MSB]) && (f_d[MSB] != s1_a_q[MSB]);
`ifdef ALU_SAT_EN
                if (c_d) f_d = {WIDTH{1'b1}};
`endif
            end
            3'd4:    f_d = s1_a_q ^ s1_b_q;
            3'd5:    f_d = s1_a_q | s1_b_q;
            3'd6:    f_d = s1_a_q & s1_b_q;
            3'd7:    f_d = {WIDTH{1'b1}};
            default: f_d = '0;
        endcase
        // Z and N follow the final (possibly clamped) result.
        z_d = (f_d == '0);
        n_d = f_d[MSB];
    end

    // Stage 1 register: capture operands on an accepted transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_op_q <= bus.s;
                s1_a_q  <= bus.A;
                s1_b_q  <= bus.B;
            end
        end
    end

    // Stage 2 register: result and flags hold while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_f_q     <= '0;
            s2_c_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_z_q     <= 1'b0;
            s2_n_q     <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_f_q <= f_d;
                s2_c_q <= c_d;
                s2_v_q <= v_d;
                s2_z_q <= z_d;
                s2_n_q <= n_d;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.F         = s2_f_q;
    assign bus.flag_c    = s2_c_q;
    assign bus.flag_v    = s2_v_q;
    assign bus.flag_z    = s2_z_q;
    assign bus.flag_n    = s2_n_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module      : tb_alu_pipe
// Description : Scoreboard bench for alu_pipe (WIDTH = 8). Directed vectors
//               push expected results; a monitor pops and compares on each
//               output handshake. Expectations follow ALU_SAT_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_alu_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_pipe_if #(.WIDTH(8)) bus ();
    alu_pipe #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [11:0] exp_q[$];       // {F, c, v, z, n}
    int          pop_cyc[$];
    int          cyc = 0;
    bit          pat_mode = 1'b0;
    logic        hold_ready = 1'b1;
    bit          saw_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [11:0] pack(input logic [7:0] f, input logic c, input logic v);
        return {f, c, v, (f == 8'h00), f[7]};
    endfunction

    // Issue one operand set; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ef, input logic ec, input logic ev);
        bit ok = 1'b0;
        logic r;
        bus.in_valid = 1'b1;
        bus.s = op;
        bus.A = a;
        bus.B = b;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            r = bus.in_ready;
            if (!r) saw_full = 1'b1;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (ok) exp_q.push_back(pack(ef, ec, ev));
        else chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        @(posedge clk);
        #1;
    endtask

    // Consumer: drives out_ready, either held or in a 1,0,0 pattern.
    initial begin
        int pidx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (pat_mode) begin
                bus.out_ready = (pidx == 0);
                pidx = (pidx + 1) % 3;
            end else begin
                bus.out_ready = hold_ready;
                pidx = 0;
            end
        end
    end

    // Monitor: compare every accepted result against the scoreboard.
    initial begin
        logic [7:0]  pf = 8'h00;
        bit          pst = 1'b0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pst = 1'b0;
            end else begin
                if (pst) begin
                    chk("stall_hold_F", {24'd0, bus.F}, {24'd0, pf});
                    chk("stall_hold_valid", {31'd0, bus.out_valid}, 32'd1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got F=%0h required none", bus.F);
                    end else begin
                        e = exp_q.pop_front();
                        chk("F", {24'd0, bus.F}, {24'd0, e[11:4]});
                        chk("flags_cvzn", {28'd0, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n},
                            {28'd0, e[3:0]});
                        pop_cyc.push_back(cyc);
                    end
                end
                pst = bus.out_valid && !bus.out_ready;
                pf  = bus.F;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.s = 3'd0;
        bus.A = 8'h00;
        bus.B = 8'h00;

        // Reset state
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_F", {24'd0, bus.F}, 32'd0);
        chk("rst_flags", {28'd0, bus.flag_c, bus.flag_v, bus.flag_z, bus.flag_n}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        #12 rst = 1'b0;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Add wrap with latency check
`ifdef ALU_SAT_EN
        send(3'd3, 8'hF0, 8'h20, 8'hFF, 1'b1, 1'b0);
`else
        send(3'd3, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
`endif
        chk("latency_edge1_valid", {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("latency_edge2_valid", {31'd0, bus.out_valid}, 32'd1);
        drain();

        // Subtract borrow, reverse subtract, overflow, constants, logic
`ifdef ALU_SAT_EN
        send(3'd2, 8'h05, 8'h09, 8'h00, 1'b1, 1'b0);
`else
        send(3'd2, 8'h05, 8'h09, 8'hFC, 1'b1, 1'b0);
`endif
        send(3'd1, 8'h05, 8'h09, 8'h04, 1'b0, 1'b0);
        send(3'd3, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        send(3'd0, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0);
        send(3'd7, 8'h12, 8'h34, 8'hFF, 1'b0, 1'b0);
        send(3'd2, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        send(3'd1, 8'h01, 8'h80, 8'h7F, 1'b0, 1'b1);
        send(3'd5, 8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0);
        send(3'd6, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0);
        send(3'd4, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b0);
        drain();

        // Backpressure and ordering: out_ready 1,0,0,...
        pat_mode = 1'b1;
        saw_full = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(3'd4, 8'(i), 8'hFF, 8'hFF ^ 8'(i), 1'b0, 1'b0);
        end
        drain();
        pat_mode = 1'b0;
        hold_ready = 1'b1;
        chk("in_ready_drops_when_full", {31'd0, saw_full}, 32'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Full throughput: 16 back-to-back ops, one result per cycle
        base = pop_cyc.size();
        for (int i = 0; i < 16; i++) begin
            send(3'd3, 8'(i), 8'(i), 8'(2 * i), 1'b0, 1'b0);
        end
        drain();
        chk("throughput_count", pop_cyc.size() - base, 32'd16);
        if (pop_cyc.size() >= base + 16)
            chk("throughput_span", pop_cyc[base + 15] - pop_cyc[base], 32'd15);

        // Reset mid-stream with both stages full
        hold_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send(3'd7, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
        send(3'd5, 8'h81, 8'h00, 8'h81, 1'b0, 1'b0);
        chk("pre_rst_full_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("pre_rst_full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_F", {24'd0, bus.F}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        send(3'd4, 8'h3C, 8'h0F, 8'h33, 1'b0, 1'b0);
        drain();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
